// File: rtl/downsampler_2x2.sv
// downsampler_2x2
//   Halves a raster-order camera stream in both axes, producing one output
//   pixel per 2x2 input block for the downstream half-resolution FIFO.
//
//   Build option DS_AVERAGE_EN:
//     defined   -> rounded 2x2 box average. A half-width line buffer holds the
//                  horizontal pair sums of each even row.
//     undefined -> pure decimation. The even-row/even-col pixel of each block
//                  is held in a half-width 8-bit buffer and emitted at the
//                  block's odd-row/odd-col pixel.
//
//   Ports
//     clock, reset      : system clock, synchronous active-high reset
//     in_valid, in_data : input pixel and its qualifier
//     in_sof            : start of frame; forces the current pixel to (0,0)
//     fifo_full         : downstream FIFO full; a result is dropped when high
//     out_valid         : FIFO write strobe, one pulse per result
//     out_data          : result pixel
//     out_colcount      : output column of out_data
//     out_rowcount      : output row of out_data
//     overflow          : sticky flag, set when a result is dropped
//     frame_done        : pulses with the last result slot of a frame
module downsampler_2x2 #(
  parameter int IN_COLS = 800,
  parameter int IN_ROWS = 600,
  parameter int CNT_W   = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_sof,
  input  logic             fifo_full,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] out_colcount,
  output logic [CNT_W-1:0] out_rowcount,
  output logic             overflow,
  output logic             frame_done
);

  localparam int HALF_COLS = IN_COLS / 2;
  localparam int LB_AW     = (HALF_COLS > 1) ? $clog2(HALF_COLS) : 1;

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IN_COLS - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IN_ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic [CNT_W-1:0] cur_col_s, cur_row_s;
  logic [LB_AW-1:0] lb_addr_s;
  logic             qualify_s, last_s, drop_s;
  logic [7:0]       result_s;

  logic             pend_q, pend_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [CNT_W-1:0] out_col_q, out_col_d, out_row_q, out_row_d;
  logic             overflow_q, overflow_d;
  logic             frame_done_q, frame_done_d;

  // Effective coordinates of the current pixel; a valid start-of-frame forces (0,0).
  always_comb begin
    if (in_valid && in_sof) begin
      cur_col_s = CNT_ZERO;
      cur_row_s = CNT_ZERO;
    end else begin
      cur_col_s = col_q;
      cur_row_s = row_q;
    end
    lb_addr_s = cur_col_s[LB_AW:1];
  end

`ifdef DS_AVERAGE_EN
  logic [7:0] latch_q, latch_d;
  logic [8:0] hsum_s;
  logic [9:0] total_s, rounded_s;
  logic       lb_we_s;
  logic [8:0] linebuf_q [0:HALF_COLS-1];

  // Horizontal pair sum, vertical block total and round-half-up average.
  always_comb begin
    if (in_valid && !cur_col_s[0]) begin
      latch_d = in_data;
    end else begin
      latch_d = latch_q;
    end
    hsum_s    = {1'b0, latch_q} + {1'b0, in_data};
    total_s   = {1'b0, hsum_s} + {1'b0, linebuf_q[lb_addr_s]};
    // Maximum total is 1020, so +2 still fits in 10 bits.
    rounded_s = total_s + 10'd2;
    result_s  = rounded_s[9:2];
    lb_we_s   = in_valid && !cur_row_s[0] && cur_col_s[0];
  end

  // Even-column pixel latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      latch_q <= 8'd0;
    end else begin
      latch_q <= latch_d;
    end
  end

  // Line buffer of even-row pair sums; contents need no reset.
  always_ff @(posedge clock) begin
    if (lb_we_s) begin
      linebuf_q[lb_addr_s] <= hsum_s;
    end
  end
`else
  logic       sb_we_s;
  logic [7:0] sampbuf_q [0:HALF_COLS-1];

  // Decimation: keep each block's top-left pixel until its bottom-right pixel.
  always_comb begin
    sb_we_s  = in_valid && !cur_row_s[0] && !cur_col_s[0];
    result_s = sampbuf_q[lb_addr_s];
  end

  // Half-width buffer of held top-left samples; contents need no reset.
  always_ff @(posedge clock) begin
    if (sb_we_s) begin
      sampbuf_q[lb_addr_s] <= in_data;
    end
  end
`endif

  // Raster counters and next-state of the output registers.
  always_comb begin
    if (in_valid) begin
      if (cur_col_s == LAST_COL) begin
        col_d = CNT_ZERO;
        if (cur_row_s == LAST_ROW) begin
          row_d = CNT_ZERO;
        end else begin
          row_d = cur_row_s + CNT_ONE;
        end
      end else begin
        col_d = cur_col_s + CNT_ONE;
        row_d = cur_row_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end

    qualify_s = in_valid && cur_row_s[0] && cur_col_s[0];
    last_s    = in_valid && (cur_col_s == LAST_COL) && (cur_row_s == LAST_ROW);
    // A pending result is lost if the FIFO is full in the cycle it would be written.
    drop_s    = pend_q && fifo_full;

    pend_d       = qualify_s;
    frame_done_d = last_s;
    overflow_d   = overflow_q || drop_s;
    if (qualify_s) begin
      out_data_d = result_s;
      out_col_d  = {1'b0, cur_col_s[CNT_W-1:1]};
      out_row_d  = {1'b0, cur_row_s[CNT_W-1:1]};
    end else begin
      out_data_d = out_data_q;
      out_col_d  = out_col_q;
      out_row_d  = out_row_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q        <= CNT_ZERO;
      row_q        <= CNT_ZERO;
      pend_q       <= 1'b0;
      out_data_q   <= 8'd0;
      out_col_q    <= CNT_ZERO;
      out_row_q    <= CNT_ZERO;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pend_q       <= pend_d;
      out_data_q   <= out_data_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // The write strobe is the registered pending flag gated by the live full flag,
  // and overflow reads high from the very cycle a result is dropped.
  assign out_valid    = pend_q && !fifo_full;
  assign overflow     = overflow_q || drop_s;
  assign out_data     = out_data_q;
  assign out_colcount = out_col_q;
  assign out_rowcount = out_row_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_downsampler_2x2.sv
// Self-checking bench for downsampler_2x2 on an 8x4 frame. A 2-D image model
// computes each expected result and its cycle directly from the block pixels.
module tb_downsampler_2x2;
  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int CW   = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_sof = 1'b0;
  logic          fifo_full = 1'b0;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [CW-1:0] out_colcount, out_rowcount;
  logic          overflow, frame_done;

  typedef struct packed {
    logic        v;
    logic [31:0] cyc;
    logic [7:0]  data;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        fd;
  } ev_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ovf_first = -1;
  int   drop_cyc = -1;
  int   full_next = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  int   img[ROWS][COLS];

  downsampler_2x2 #(.IN_COLS(COLS), .IN_ROWS(ROWS), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_sof(in_sof), .fifo_full(fifo_full), .out_valid(out_valid),
    .out_data(out_data), .out_colcount(out_colcount), .out_rowcount(out_rowcount),
    .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record output events on the falling edge.
  always @(negedge clock) begin
    if (out_valid === 1'b1 || frame_done === 1'b1) begin
      if (out_valid === 1'b1)
        obs_q.push_back('{1'b1, 32'(cyc), out_data, out_colcount, out_rowcount, frame_done});
      else
        obs_q.push_back('{1'b0, 32'(cyc), 8'd0, 10'd0, 10'd0, frame_done});
    end
    if (overflow === 1'b1 && ovf_first < 0) ovf_first = cyc;
  end

  function automatic string fmt(input ev_t e);
    return $sformatf("v=%0d cyc=%0d data=%0d col=%0d row=%0d fd=%0d",
                     e.v, e.cyc, e.data, e.col, e.row, e.fd);
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic sof);
    @(posedge clock); #1;
    in_valid  = v;
    in_data   = d;
    in_sof    = sof;
    fifo_full = (full_next != 0);
    full_next = 0;
  endtask

  // kind: 0 const 100, 1 block [1,2/3,4] else 255, 2 gradient 16r+c, 3 random
  // gap : 0 none, 1 idle after every pixel, 2 random idles
  task automatic run_frame(input int kind, input int gap, input int drop_k, input bit sof_first);
    int k;
    int val;
    bit fd;
    k = 0;
    obs_q.delete();
    exp_q.delete();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        case (kind)
          0: img[r][c] = 100;
          1: img[r][c] = (r < 2 && c < 2) ? (r * 2 + c + 1) : 255;
          2: img[r][c] = 16 * r + c;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        drive(1'b1, 8'(img[r][c]), sof_first && r == 0 && c == 0);
        if ((r % 2) == 1 && (c % 2) == 1) begin
          k++;
`ifdef DS_AVERAGE_EN
          val = (img[r-1][c-1] + img[r-1][c] + img[r][c-1] + img[r][c] + 2) / 4;
`else
          val = img[r-1][c-1];
`endif
          fd = (r == ROWS - 1) && (c == COLS - 1);
          if (k == drop_k) begin
            full_next = 1;
            drop_cyc  = cyc + 1;
            if (fd) exp_q.push_back('{1'b0, 32'(cyc + 1), 8'd0, 10'd0, 10'd0, 1'b1});
          end else begin
            exp_q.push_back('{1'b1, 32'(cyc + 1), 8'(val), 10'(c / 2), 10'(r / 2), fd});
          end
        end
        if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0))
          drive(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      end
    end
    repeat (3) drive(1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({out_valid, out_data, out_colcount, out_rowcount, overflow, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%0d col=%0d row=%0d ovf=%b fd=%b expected all 0",
               out_valid, out_data, out_colcount, out_rowcount, overflow, frame_done);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    ovf_first = -1;
  endtask

  task automatic test_constant();
    run_frame(0, 0, 0, 1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL const_count got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL const[%0d] got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    checks++;
    if (ovf_first !== -1) begin
      errors++;
      $display("FAIL const_overflow got set at cycle %0d expected never", ovf_first);
    end
  endtask

  task automatic test_block();
    run_frame(1, 0, 0, 1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL block_count got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL block[%0d] got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_gaps();
    for (int g = 0; g < 2; g++) begin
      run_frame(2, g, 0, 1'b0);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL gaps%0d_count got %0d expected %0d", g, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL gaps%0d[%0d] got %s expected %s", g, i, fmt(obs_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    ovf_first = -1;
    run_frame(3, 0, 3, 1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp[%0d] got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    checks++;
    if (ovf_first !== drop_cyc) begin
      errors++;
      $display("FAIL bp_overflow_rise got cycle %0d expected %0d", ovf_first, drop_cyc);
    end
    repeat (5) drive(1'b0, 8'd0, 1'b0);
    @(negedge clock);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow_sticky got %b expected 1", overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int p = 0; p < COLS + 3; p++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({out_valid, out_data, out_colcount, out_rowcount, overflow, frame_done} !== '0) begin
      errors++;
      $display("FAIL midreset_state got v=%b d=%0d col=%0d row=%0d ovf=%b fd=%b expected all 0",
               out_valid, out_data, out_colcount, out_rowcount, overflow, frame_done);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    ovf_first = -1;
    run_frame(2, 0, 0, 1'b1);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL midreset_count got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset[%0d] got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_sof_realign();
    for (int p = 0; p < 5; p++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    run_frame(3, 0, 0, 1'b1);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL sof_count got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sof[%0d] got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      run_frame(3, 2, 0, 1'b0);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count got %0d expected %0d", f, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d[%0d] got %s expected %s", f, i, fmt(obs_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_block();
    test_gaps();
    test_sof_realign();
    test_random();
    test_backpressure();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
